// File: rtl/freq_pkg.sv
// Shared definitions for the frequency synthesizer: FSM encoding and
// the helper that sizes the divider from the clock rate.
package freq_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_DIV     = 3'd1;
    localparam logic [2:0] ST_RUN     = 3'd2;
    localparam logic [2:0] ST_RUN_DIV = 3'd3;
    localparam logic [2:0] ST_ERR     = 3'd4;

    function automatic int qw_of(input int clk_hz);
        return $clog2(clk_hz + 1);
    endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock; quotient and remainder
// registers are shifted in place. Requires DW >= 2.
module seq_divider #(
    parameter int DW = 10,
    parameter int VW = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic [DW-1:0] quotient,
    output logic          valid
);
    localparam int CW = $clog2(DW + 1);

    // remainder stays below the divisor, so one extra bit holds the shifted trial
    logic [VW:0]   rem;
    logic [VW-1:0] dvs;
    logic [CW-1:0] cnt;
    logic [VW:0]   trial;
    logic          fits;

    always_comb begin
        trial = {rem[VW-1:0], quotient[DW-1]};
        fits  = trial >= {1'b0, dvs};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy     <= 1'b0;
            valid    <= 1'b0;
            rem      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            quotient <= '0;
        end else begin
            valid <= 1'b0;
            if (abort) begin
                busy <= 1'b0;
            end else if (start && !busy) begin
                rem      <= '0;
                dvs      <= divisor;
                quotient <= dividend;
                cnt      <= CW'(DW);
                busy     <= 1'b1;
            end else if (busy) begin
                rem      <= fits ? trial - {1'b0, dvs} : trial;
                quotient <= {quotient[DW-2:0], fits};
                cnt      <= cnt - 1'b1;
                if (cnt == CW'(1)) begin
                    busy  <= 1'b0;
                    valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/freq_synth.sv
// Programmable 50%-duty square-wave source: converts a frequency in Hz to a
// half-period count and retunes on a wave toggle so no phase is ever cut short.
module freq_synth
    import freq_pkg::*;
#(
    parameter  int CLK_HZ = 100_000_000,
    parameter  int FW     = 26,
    localparam int QW     = qw_of(CLK_HZ)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [FW-1:0] freq_hz,
    input  logic          start,
    input  logic          stop,
    output logic          wave,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [QW-1:0] half_period
);
    localparam int WW = QW + FW + 1;

    logic [2:0]    state;
    logic [QW-1:0] cnt;
    logic [QW-1:0] pend_h;
    logic          pend;
    logic [FW:0]   two_f;
    logic          bad, accept, running, toggle, commit;
    logic          div_valid;
    logic [QW-1:0] quo;

    assign two_f   = {freq_hz, 1'b0};
    assign bad     = (freq_hz == '0) || (WW'(two_f) > WW'(CLK_HZ));
    assign accept  = start && !stop &&
                     (state == ST_IDLE || state == ST_RUN || state == ST_ERR);
    assign running = (state == ST_RUN) || (state == ST_RUN_DIV);
    assign toggle  = running && (cnt == half_period - 1'b1);
    // a result arriving on a toggle cycle is committed straight from the divider
    assign commit  = (state == ST_RUN_DIV) && toggle && (pend || div_valid);

    seq_divider #(.DW(QW), .VW(FW + 1)) u_div (
        .clk      (clk),
        .reset    (reset),
        .start    (accept && !bad),
        .abort    (stop),
        .dividend (QW'(CLK_HZ)),
        .divisor  (two_f),
        .busy     (busy),
        .quotient (quo),
        .valid    (div_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            wave        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            half_period <= '0;
            cnt         <= '0;
            pend        <= 1'b0;
            pend_h      <= '0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state       <= ST_IDLE;
                wave        <= 1'b0;
                half_period <= '0;
                cnt         <= '0;
                pend        <= 1'b0;
            end else begin
                if (running) begin
                    if (toggle) begin
                        wave <= ~wave;
                        cnt  <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                if (accept) begin
                    err <= bad;
                    if (bad) begin
                        state       <= ST_ERR;
                        wave        <= 1'b0;
                        half_period <= '0;
                        cnt         <= '0;
                    end else begin
                        state <= (state == ST_RUN) ? ST_RUN_DIV : ST_DIV;
                    end
                end else begin
                    case (state)
                        ST_DIV: if (div_valid) begin
                            half_period <= quo;
                            done        <= 1'b1;
                            wave        <= 1'b0;
                            cnt         <= '0;
                            state       <= ST_RUN;
                        end
                        ST_RUN_DIV: begin
                            if (div_valid) begin
                                pend   <= 1'b1;
                                pend_h <= quo;
                            end
                            if (commit) begin
                                half_period <= pend ? pend_h : quo;
                                done        <= 1'b1;
                                pend        <= 1'b0;
                                state       <= ST_RUN;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_freq_synth.sv
// Bench for freq_synth at CLK_HZ=1000, FW=10: vector table for single tunes,
// hand sequences for retune, busy/stop interaction and asynchronous reset.
module tb_freq_synth;
    localparam int CLK_HZ = 1000;
    localparam int FW     = 10;
    localparam int QW     = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [FW-1:0] freq_hz = '0;
    logic          wave, busy, done, err;
    logic [QW-1:0] half_period;

    freq_synth #(.CLK_HZ(CLK_HZ), .FW(FW)) dut (
        .clk         (clk),
        .reset       (reset),
        .freq_hz     (freq_hz),
        .start       (start),
        .stop        (stop),
        .wave        (wave),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .half_period (half_period)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int done_cnt = 0;
    int mon_e;

    typedef struct {
        int f;
        bit e;
        int h;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    // scoreboard: every done pulse must match the oldest expected half_period
    always @(negedge clk) begin
        if (!reset && done) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done got=%0d exp=none", half_period);
            end else begin
                mon_e = exp_q.pop_front();
                if (half_period !== QW'(mon_e)) begin
                    errors++;
                    $display("FAIL done_half_period got=%0d exp=%0d", half_period, mon_e);
                end
            end
            done_cnt++;
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int base, input string name);
        int n = 0;
        while (done_cnt <= base && n < 40) begin
            step();
            n++;
        end
        if (done_cnt <= base) check({name, "_timeout"}, 0, 1);
    endtask

    task automatic do_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("stop_wave", wave, 0);
        check("stop_half", half_period, 0);
        check("stop_busy", busy, 0);
    endtask

    task automatic tune(input int f, input int h);
        int base;
        base = done_cnt;
        exp_q.push_back(h);
        freq_hz = FW'(f);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(base, "tune");
    endtask

    initial begin
        int base, n, lo, hi, kd, kexp, nb, prev;
        bit w[80], d[80], b[80];
        int tog[$];

        vecs[0] = '{100, 1'b0, 5};
        vecs[1] = '{300, 1'b0, 1};
        vecs[2] = '{500, 1'b0, 1};
        vecs[3] = '{501, 1'b1, 0};
        vecs[4] = '{0,   1'b1, 0};
        vecs[5] = '{100, 1'b0, 5};
        vecs[6] = '{7,   1'b0, 71};
        vecs[7] = '{1,   1'b0, 500};

        step();
        check("rst_wave", wave, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_half", half_period, 0);
        reset = 1'b0;
        step();

        foreach (vecs[i]) begin
            do_stop();
            base = done_cnt;
            if (!vecs[i].e) exp_q.push_back(vecs[i].h);
            freq_hz = FW'(vecs[i].f);
            start = 1'b1;
            step();
            start = 1'b0;
            check("vec_err", err, vecs[i].e);
            if (vecs[i].e) begin
                check("vec_err_wave", wave, 0);
                check("vec_err_half", half_period, 0);
                check("vec_err_busy", busy, 0);
                repeat (15) step();
                check("vec_err_wave_hold", wave, 0);
            end else begin
                n = 0;
                while (busy && n < 50) begin
                    n++;
                    step();
                end
                check("vec_busy_cycles", n, QW);
                wait_done(base, "vec");
                check("vec_commit_wave", wave, 0);
                lo = 0;
                while (!wave && lo < 1100) begin
                    lo++;
                    step();
                end
                hi = 0;
                while (wave && hi < 1100) begin
                    hi++;
                    step();
                end
                check("vec_low_phase", lo, vecs[i].h);
                check("vec_high_phase", hi, vecs[i].h);
            end
        end

        // retune while running: 100 Hz (H=5) -> 50 Hz (H=10)
        do_stop();
        tune(100, 5);
        repeat (7) step();
        exp_q.push_back(10);
        freq_hz = FW'(50);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 80; k++) begin
            w[k] = wave;
            d[k] = done;
            b[k] = busy;
            step();
        end
        nb = 0;
        kd = -1;
        kexp = -1;
        for (int k = 0; k < 80; k++) begin
            if (b[k]) nb++;
            if (d[k] && kd < 0) kd = k;
            if (k >= 11 && kexp < 0 && w[k] != w[k-1]) kexp = k;
            if (k >= 1 && w[k] != w[k-1]) tog.push_back(k);
        end
        check("retune_busy_cycles", nb, QW);
        check("retune_done_at_toggle", kd, kexp);
        prev = -1;
        foreach (tog[j]) begin
            if (prev >= 0) check("retune_phase", tog[j] - prev, (tog[j] <= kd) ? 5 : 10);
            prev = tog[j];
        end

        // second start while dividing is dropped
        do_stop();
        base = done_cnt;
        exp_q.push_back(5);
        freq_hz = FW'(100);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        freq_hz = FW'(50);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(base, "busy_ignore");
        repeat (20) step();

        // stop and start together: stop wins
        stop = 1'b1;
        start = 1'b1;
        freq_hz = FW'(100);
        step();
        stop = 1'b0;
        start = 1'b0;
        check("stopstart_wave", wave, 0);
        check("stopstart_half", half_period, 0);
        check("stopstart_busy", busy, 0);
        repeat (15) step();
        check("stopstart_idle_wave", wave, 0);

        // asynchronous reset mid-division
        exp_q.push_back(5);
        freq_hz = FW'(100);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        #1;
        check("rstdiv_busy", busy, 0);
        check("rstdiv_half", half_period, 0);
        check("rstdiv_wave", wave, 0);
        exp_q.delete();
        step();
        reset = 1'b0;
        step();
        tune(100, 5);

        // asynchronous reset mid-run while wave is high
        n = 0;
        while (!wave && n < 20) begin
            n++;
            step();
        end
        check("rstrun_wave_high", wave, 1);
        reset = 1'b1;
        #1;
        check("rstrun_wave", wave, 0);
        check("rstrun_half", half_period, 0);
        check("rstrun_err", err, 0);
        step();
        reset = 1'b0;
        step();
        tune(300, 1);
        repeat (4) step();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
